tod_tx: RTL
===========

Name: tod_tx

Overview:
- Transmit side of the TOD serial link. After each PPS rising edge and a programmable delay, it sends one fixed-format TOD frame over a UART line (8N1, LSB first).
- The frame carries the current week, week-second, leap-second and status fields, followed by an 8-bit additive checksum.
- Sits beside the PPS generator in the clk_125m domain and drives the board TOD output pin for downstream slaves.

Parameters:
- BAUD_DIV, 1085: clk_125m cycles per UART bit (115200 baud); legal range 2..65535.
- TX_DELAY, 125000: cycles from PPS edge detect to frame start (1 ms); legal range ≥1.
- HDR0, 8'h55: first header byte.
- HDR1, 8'hAA: second header byte.

Ports:
- clk_125m  in  1  system clock, 125 MHz.
- rst  in  1  asynchronous reset, active-high.
- pps_in  in  1  PPS pulse, synchronous to clk_125m.
- tx_en  in  1  frame generation enable.
- week  in  16  GPS week.
- week_sec  in  32  seconds into the week.
- leap_sec  in  8  leap seconds.
- pps_state  in  8  PPS status.
- timesrc_type  in  8  time source type.
- pps_precision  in  8  PPS precision code.
- tod_out  out  1  UART serial output; idles high.
- busy  out  1  high from PPS accept until the end of the frame.
- frame_done  out  1  one-cycle pulse when a frame completes.
- pps_miss  out  1  one-cycle pulse when a PPS edge is rejected.

Behaviour:
- Reset values: tod_out=1, busy=0, frame_done=0, pps_miss=0. FSM=IDLE, all counters 0.
- PPS edge detect:
  - pps_in goes through one register; edge = pps_in & ~pps_q.
  - Edge cycle k is the first clock edge sampling pps_in=1 after a 0.
- Edge acceptance:
  - An edge is accepted only in IDLE with tx_en=1.
  - An edge arriving in any other state, or with tx_en=0, is ignored and pulses pps_miss for 1 cycle.
- States: IDLE, WAIT, LOAD, START, DATA, STOP.
  - IDLE: on an accepted edge at k, go to WAIT; busy=1 from k+1.
  - WAIT: count TX_DELAY cycles, then go to LOAD.
  - LOAD (1 cycle):
    - Snapshot all field inputs into the frame shadow.
    - Compute checksum = (sum of the 10 payload bytes) mod 256.
    - Set byte index to 0.
    - Input changes after LOAD do not affect the frame.
  - START: tod_out=0 for BAUD_DIV cycles. The first start bit falls at edge k+TX_DELAY+2.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each.
  - STOP: tod_out=1 for BAUD_DIV cycles.
    - If byte index < 12: increment it and go to START (no inter-byte gap).
    - Otherwise: go to IDLE, busy=0 and frame_done=1 in the same cycle.
- Frame byte order (13 bytes), with week and week_sec sent big-endian:
  - HDR0, HDR1
  - week[15:8], week[7:0]
  - week_sec[31:24], [23:16], [15:8], [7:0]
  - leap_sec, pps_state, timesrc_type, pps_precision
  - checksum
- Frame length: exactly 130*BAUD_DIV cycles from the first start-bit fall to frame_done.
- Bit timer: counts 0..BAUD_DIV-1 and wraps with no drift; the bit counter wraps 0..7.
- tx_en deasserted mid-frame (WAIT or later): the current frame completes normally. Only new edges are gated.
- An edge in the same cycle as frame_done (FSM still in STOP) is rejected, with a pps_miss pulse.
- Asynchronous reset mid-frame: tod_out returns high immediately, FSM goes to IDLE, no frame_done pulse.

Test Plan (BAUD_DIV=4, TX_DELAY=10 unless noted):
1. Field capture and checksum.
   - Stimulus: week=16'h0823, week_sec=32'h0001_5180, leap=8'h12, state=8'h01, src=8'h02, prec=8'h03, one PPS edge at k.
   - Required: tod_out falls at k+12. Decoded bytes are 55 AA 08 23 00 01 51 80 12 01 02 03 15. frame_done pulses exactly 520 cycles after the first fall; busy spans k+1 to the frame_done cycle.
2. Bit timing, BAUD_DIV=1085.
   - Stimulus: one frame.
   - Required: every bit lasts exactly 1085 cycles; the frame lasts 141050 cycles.
3. PPS rejection.
   - Stimulus: a second PPS edge during WAIT, another during DATA, and one with tx_en=0 in IDLE.
   - Required: pps_miss pulses each time; only one frame is sent.
4. Input stability.
   - Stimulus: change week to 16'hFFFF two cycles after LOAD.
   - Required: the transmitted week bytes still carry the LOAD-time value.
5. Mid-frame reset.
   - Stimulus: assert rst during byte 5.
   - Required: tod_out=1 and busy=0 immediately; no frame_done. The next PPS after release produces a complete, correct frame.
6. Checksum wrap.
   - Stimulus: all payload fields 8'hFF-filled.
   - Required: checksum byte = 10*255 mod 256 = 8'hF6.

Source files
------------

// File: rtl/tod_tx.sv
// tod_tx: transmit side of the TOD serial link.
// After each accepted PPS rising edge and a programmable delay, it sends one
// 13-byte TOD frame (header, week, week-second, leap, status fields and an
// additive checksum) as 8N1 UART, LSB first, on tod_out.
module tod_tx #(
    parameter int          BAUD_DIV = 1085,    // clk_125m cycles per UART bit
    parameter int          TX_DELAY = 125000,  // cycles from PPS edge to frame start
    parameter logic [7:0]  HDR0     = 8'h55,
    parameter logic [7:0]  HDR1     = 8'hAA
) (
    input  logic        clk_125m,
    input  logic        rst,
    input  logic        pps_in,
    input  logic        tx_en,
    input  logic [15:0] week,
    input  logic [31:0] week_sec,
    input  logic [7:0]  leap_sec,
    input  logic [7:0]  pps_state,
    input  logic [7:0]  timesrc_type,
    input  logic [7:0]  pps_precision,
    output logic        tod_out,
    output logic        busy,
    output logic        frame_done,
    output logic        pps_miss
);

    localparam int          FRAME_BYTES   = 13;
    localparam int          PAYLOAD_BYTES = 10;
    localparam logic [15:0] BAUD_LAST     = 16'(BAUD_DIV - 1);
    // WAIT leaves when the counter reaches TX_DELAY, so the first start bit
    // lands TX_DELAY+2 edges after the accepted PPS edge (one for LOAD).
    localparam logic [31:0] WAIT_LAST     = 32'(TX_DELAY);
    localparam logic [3:0]  LAST_BYTE     = 4'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t      state_reg;
    logic        pps_q_reg;
    logic        pps_edge;
    logic [31:0] wait_cnt_reg;
    logic [15:0] baud_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [3:0]  byte_idx_reg;
    logic        tod_out_reg;
    logic        busy_reg;
    logic        frame_done_reg;
    logic        pps_miss_reg;

    // Frame shadow, written only in LOAD so later input changes are ignored.
    logic [7:0]  frame_reg  [FRAME_BYTES];
    logic [7:0]  frame_next [FRAME_BYTES];
    logic [7:0]  cur_byte;

    // Payload in transmit order; multi-byte fields go out big-endian.
    logic [8*PAYLOAD_BYTES-1:0] payload_flat;
    logic [7:0]                 payload_byte [PAYLOAD_BYTES];
    logic [7:0]                 checksum_next;

    assign pps_edge     = pps_in & ~pps_q_reg;
    assign payload_flat = {week, week_sec, leap_sec, pps_state, timesrc_type, pps_precision};

    generate
        for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_payload
            assign payload_byte[gi]   = payload_flat[8*PAYLOAD_BYTES-1-8*gi -: 8];
            assign frame_next[gi + 2] = payload_byte[gi];
        end
    endgenerate

    assign frame_next[0]               = HDR0;
    assign frame_next[1]               = HDR1;
    assign frame_next[FRAME_BYTES - 1] = checksum_next;

    // Additive checksum over the ten payload bytes; the 8-bit sum wraps mod 256.
    always_comb begin
        checksum_next = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            checksum_next = checksum_next + payload_byte[i];
        end
    end

    // Snapshot all frame bytes in the single LOAD cycle.
    always_ff @(posedge clk_125m) begin
        if (state_reg == S_LOAD) begin
            for (int i = 0; i < FRAME_BYTES; i++) begin
                frame_reg[i] <= frame_next[i];
            end
        end
    end

    assign cur_byte = frame_reg[byte_idx_reg];

    // Frame FSM: edge acceptance, delay, and bit-serial UART output.
    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            pps_q_reg      <= 1'b0;
            wait_cnt_reg   <= '0;
            baud_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            byte_idx_reg   <= '0;
            tod_out_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            pps_miss_reg   <= 1'b0;
        end else begin
            pps_q_reg      <= pps_in;
            frame_done_reg <= 1'b0;
            // Any edge not taken by IDLE with tx_en set is reported as a miss,
            // including one coinciding with the final STOP cycle.
            pps_miss_reg   <= pps_edge & ~((state_reg == S_IDLE) & tx_en);

            case (state_reg)
                S_IDLE: begin
                    if (pps_edge && tx_en) begin
                        state_reg    <= S_WAIT;
                        wait_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg    <= S_LOAD;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 32'd1;
                    end
                end

                S_LOAD: begin
                    state_reg    <= S_START;
                    byte_idx_reg <= '0;
                    bit_cnt_reg  <= '0;
                    baud_cnt_reg <= '0;
                    tod_out_reg  <= 1'b0;
                end

                S_START: begin
                    if (baud_cnt_reg == BAUD_LAST) begin
                        state_reg    <= S_DATA;
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        tod_out_reg  <= cur_byte[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end

                S_DATA: begin
                    if (baud_cnt_reg == BAUD_LAST) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg   <= S_STOP;
                            bit_cnt_reg <= '0;
                            tod_out_reg <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            tod_out_reg <= cur_byte[bit_cnt_reg + 3'd1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end

                S_STOP: begin
                    if (baud_cnt_reg == BAUD_LAST) begin
                        baud_cnt_reg <= '0;
                        if (byte_idx_reg < LAST_BYTE) begin
                            // Next start bit follows the stop bit with no gap.
                            state_reg    <= S_START;
                            byte_idx_reg <= byte_idx_reg + 4'd1;
                            tod_out_reg  <= 1'b0;
                        end else begin
                            state_reg      <= S_IDLE;
                            byte_idx_reg   <= '0;
                            busy_reg       <= 1'b0;
                            frame_done_reg <= 1'b1;
                            tod_out_reg    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 16'd1;
                    end
                end

                default: begin
                    state_reg   <= S_IDLE;
                    busy_reg    <= 1'b0;
                    tod_out_reg <= 1'b1;
                end
            endcase
        end
    end

    assign tod_out    = tod_out_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign pps_miss   = pps_miss_reg;

endmodule
